vec_sum_pipe: RTL and testbench
===============================

Name: vec_sum_pipe

Overview:
- Pipelined, parametrised successor to the combinational integer vector-sum tree.
- Reduces a `length`-element vector per beat through a registered binary adder tree, with signed or unsigned operands.
- Accumulates tree results across a multi-beat packet delimited by `i_last`, and emits one sum per packet.
- Valid/ready on both sides; sits between per-element product generation and block-scale/normalisation logic in MX dot-product datapaths.

Parameters:
- `bit_width`, 16: width of each input element.
- `length`, 32: elements per beat; any value ≥2, need not be a power of two.
- `is_signed`, 1: 1 = elements and sums are two's complement, 0 = unsigned.
- `reg_every`, 1: pipeline register inserted after every `reg_every` tree levels; range 1..`tree_depth`.
- `acc_extra`, 8: extra accumulator bits beyond the tree sum width.
- `tree_depth`, `$clog2(length)`: adder levels (derived).
- `sum_width`, `bit_width+tree_depth`: exact tree result width (derived).
- `acc_width`, `sum_width+acc_extra`: output width (derived).

Ports:
- `i_clk` input 1: clock, all state on rising edge.
- `i_rst_n` input 1: synchronous active-low reset.
- `i_valid` input 1: input beat valid.
- `o_ready` output 1: block can accept a beat.
- `i_vec` input `bit_width` × [`length`]: element array.
- `i_last` input 1: beat is the final beat of its packet.
- `o_valid` output 1: `o_sum` / `o_ovf` valid.
- `i_ready` input 1: downstream accepts output.
- `o_sum` output `acc_width`: packet sum.
- `o_ovf` output 1: packet accumulation overflowed `acc_width`.

Behaviour:
- Reset (`i_rst_n`=0 at an edge):
  - `o_valid`=0, `o_sum`=0, `o_ovf`=0.
  - All stage valids=0; accumulator=0; first-beat flag=1.
  - Reset mid-packet discards all in-flight beats and any partial accumulation.
- Input handshake:
  - Beat accepted when `i_valid` & `o_ready`.
  - `o_ready` = ~(`o_valid` & ~`i_ready`), combinational from state and `i_ready` only, never from `i_valid`.
- Global enable `en` = `o_ready`:
  - When `en`=0, every pipeline register, stage valid, accumulator and output holds.
- Tree:
  - Elements are sign-extended (`is_signed`=1) or zero-extended to `sum_width`.
  - Pad to 2^`tree_depth` elements with zeros, then pairwise add level by level.
  - Tree results are exact; no tree overflow is possible.
- Pipeline depth S = ceil(`tree_depth`/`reg_every`) tree stages, plus one accumulate/output stage.
  - Latency from acceptance of a last beat to `o_valid`=1 is S+1 cycles, with no backpressure.
  - Default parameters: S=5, latency 6.
- Each stage carries a valid bit and the beat's `i_last`; bubbles (valid=0) propagate and do not touch the accumulator.
- Accumulate stage, when tree-output valid & `en`:
  - `acc_next` = (first ? 0 : acc) + tree_sum, extended to `acc_width + 1` for overflow detection.
  - Signed overflow: result outside the signed `acc_width` range. Unsigned overflow: carry out.
  - Overflow sets the packet ovf flag; the flag is cleared at packet start (first=1).
  - Wrapped `acc_next` is kept: `acc_width` bits, two's-complement wrap.
  - If last:
    - `o_sum` ← `acc_next`, `o_ovf` ← packet ovf, `o_valid` ← 1.
    - first ← 1.
  - If not last: acc ← `acc_next`, first ← 0.
- Output:
  - `o_valid` clears on `i_ready` & `o_valid` unless a new last result loads in the same cycle.
  - A new load in that cycle keeps `o_valid`=1 with the new data.
- Single-beat packets (`i_last`=1 every beat) give one output per beat at full throughput, back to back, with no bubbles.
- Boundary cases:
  - `length`=2 gives `tree_depth`=1, S=1.
  - `reg_every`=`tree_depth` gives a single tree register stage.

Test Plan:
- **Unsigned single beat:** `is_signed`=0, all 32 elements = 16'hFFFF, `i_last`=1 → after 6 cycles `o_sum`=32×65535=2097120, `o_ovf`=0.
- **Signed multi-beat:** `is_signed`=1, 3 beats of all elements = -1, last on beat 3 → a single output `o_sum`=-96 (sign-extended over 29 bits), 6 cycles after beat 3; no output for beats 1–2.
- **Backpressure:** stream 10 single-beat packets with value k on element 0, others 0, while `i_ready` toggles 1,0,0,1 → outputs 0..9 in order, none lost or duplicated; `o_ready`=0 exactly when `o_valid`=1 & `i_ready`=0.
- **Overflow:** `acc_extra`=0, `is_signed`=0, 2 beats of all 16'hFFFF → `o_ovf`=1 and `o_sum`=(2×2097120) mod 2^21; the next packet of zeros gives `o_ovf`=0.
- **Reset mid-packet:** send 2 non-last beats of value 1, pulse `i_rst_n` low for one cycle, then send a one-beat last packet of value 2 per element → `o_sum`=64, with no contribution from the pre-reset beats.
- **Non-power-of-two length:** `length`=5, `reg_every`=2, elements 1,2,3,4,5 signed → `o_sum`=15 after S+1=3 cycles.

Source files
------------

// File: rtl/vec_sum_pipe.sv
// Pipelined vector reduction: registered binary adder tree feeding a per-packet accumulator.
// A single global enable (o_ready) stalls every stage together when the output is held.
module vec_sum_pipe #(
  parameter int bit_width = 16,
  parameter int length    = 32,
  parameter int is_signed = 1,
  parameter int reg_every = 1,
  parameter int acc_extra = 8,
  localparam int tree_depth = $clog2(length),
  localparam int sum_width  = bit_width + tree_depth,
  localparam int acc_width  = sum_width + acc_extra
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [length-1:0][bit_width-1:0]  i_vec,
  input  logic                              i_last,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [acc_width-1:0]              o_sum,
  output logic                              o_ovf
);

  localparam int pad_len = 1 << tree_depth;
  localparam int ext_w   = sum_width - bit_width;

  logic en;
  logic o_valid_q, o_valid_d;

  assign o_ready = ~(o_valid_q & ~i_ready);
  assign en      = o_ready;

  logic [sum_width-1:0] leaf [pad_len];

  always_comb begin
    for (int i = 0; i < pad_len; i++) begin
      leaf[i] = '0;
    end
    for (int i = 0; i < length; i++) begin
      leaf[i] = {{ext_w{(is_signed != 0) & i_vec[i][bit_width-1]}}, i_vec[i]};
    end
  end

  // Level l is registered every reg_every levels and always at the root.
  for (genvar l = 1; l <= tree_depth; l++) begin : g_lvl
    localparam int n_node = pad_len >> l;
    localparam bit is_reg = ((l % reg_every) == 0) || (l == tree_depth);

    logic [sum_width-1:0] in_v  [2*n_node];
    logic [sum_width-1:0] sum_d [n_node];
    logic [sum_width-1:0] out_v [n_node];
    logic                 vld_d, lst_d;
    logic                 out_vld, out_lst;

    if (l == 1) begin : g_src
      assign in_v  = leaf;
      assign vld_d = i_valid;
      assign lst_d = i_last;
    end else begin : g_src
      assign in_v  = g_lvl[l-1].out_v;
      assign vld_d = g_lvl[l-1].out_vld;
      assign lst_d = g_lvl[l-1].out_lst;
    end

    always_comb begin
      for (int i = 0; i < n_node; i++) begin
        sum_d[i] = in_v[2*i] + in_v[2*i+1];
      end
    end

    if (is_reg) begin : g_reg
      logic [sum_width-1:0] sum_q [n_node];
      logic                 vld_q, lst_q;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          vld_q <= 1'b0;
          lst_q <= 1'b0;
          for (int i = 0; i < n_node; i++) begin
            sum_q[i] <= '0;
          end
        end else if (en) begin
          vld_q <= vld_d;
          lst_q <= lst_d;
          sum_q <= sum_d;
        end
      end

      assign out_v   = sum_q;
      assign out_vld = vld_q;
      assign out_lst = lst_q;
    end else begin : g_comb
      assign out_v   = sum_d;
      assign out_vld = vld_d;
      assign out_lst = lst_d;
    end
  end

  logic [sum_width-1:0] t_sum;
  logic                 t_vld, t_lst;

  assign t_sum = g_lvl[tree_depth].out_v[0];
  assign t_vld = g_lvl[tree_depth].out_vld;
  assign t_lst = g_lvl[tree_depth].out_lst;

  logic [acc_width-1:0] acc_q, acc_d, o_sum_q, o_sum_d;
  logic                 first_q, first_d, ovf_q, ovf_d, o_ovf_q, o_ovf_d;
  logic [acc_width:0]   ts_ext, base_ext, acc_full;
  logic                 ovf_now, pkt_ovf;

  // One guard bit above acc_width exposes carry-out or signed range violation.
  always_comb begin
    ts_ext   = {{(acc_extra+1){(is_signed != 0) & t_sum[sum_width-1]}}, t_sum};
    base_ext = '0;
    if (!first_q) begin
      base_ext = {(is_signed != 0) & acc_q[acc_width-1], acc_q};
    end
    acc_full = base_ext + ts_ext;
    if (is_signed != 0) begin
      ovf_now = acc_full[acc_width] ^ acc_full[acc_width-1];
    end else begin
      ovf_now = acc_full[acc_width];
    end
    pkt_ovf = ovf_now | (ovf_q & ~first_q);

    acc_d     = acc_q;
    first_d   = first_q;
    ovf_d     = ovf_q;
    o_sum_d   = o_sum_q;
    o_ovf_d   = o_ovf_q;
    o_valid_d = o_valid_q;

    if (o_valid_q && i_ready) begin
      o_valid_d = 1'b0;
    end
    if (en && t_vld) begin
      if (t_lst) begin
        o_sum_d   = acc_full[acc_width-1:0];
        o_ovf_d   = pkt_ovf;
        o_valid_d = 1'b1;
        first_d   = 1'b1;
      end else begin
        acc_d   = acc_full[acc_width-1:0];
        ovf_d   = pkt_ovf;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      o_sum_q   <= '0;
      o_ovf_q   <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      first_q   <= first_d;
      ovf_q     <= ovf_d;
      o_sum_q   <= o_sum_d;
      o_ovf_q   <= o_ovf_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_sum   = o_sum_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_vec_sum_pipe.sv
// Scoreboard bench for vec_sum_pipe across several parameter sets, each with its own
// packet-level arithmetic model, driver, ready generator and output monitor.
module tb_vec_sum_pipe;

  localparam int NCFG = 5;

  typedef struct {
    longint sum;
    bit     ovf;
    int     acc_cyc;
    bit     lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int n_chk  = 0;
  int n_err  = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int L  = (g == 2) ? 5 : (g == 3) ? 2 : (g == 4) ? 7 : 32;
    localparam int SG = (g == 1 || g == 3) ? 0 : 1;
    localparam int RE = (g == 2) ? 2 : (g == 4) ? 3 : 1;
    localparam int AE = (g == 1) ? 0 : (g == 3) ? 3 : (g == 4) ? 2 : 8;
    localparam int TD = $clog2(L);
    localparam int AW = 16 + TD + AE;
    localparam int S  = (TD + RE - 1) / RE;

    logic                 rst_n, iv, il, ir, ov, ory, oo;
    logic [L-1:0][15:0]   vec;
    logic [AW-1:0]        os;

    exp_t   sb[$];
    longint m_acc;
    bit     m_first, m_ovf;
    int     n_out, n_pkt, ready_mode, ph;

    vec_sum_pipe #(
      .bit_width(16), .length(L), .is_signed(SG), .reg_every(RE), .acc_extra(AE)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv), .o_ready(ory), .i_vec(vec),
      .i_last(il), .o_valid(ov), .i_ready(ir), .o_sum(os), .o_ovf(oo)
    );

    function automatic longint wrap(input longint s);
      longint m;
      m = s & ((longint'(1) << AW) - 1);
      if (SG != 0 && m >= (longint'(1) << (AW - 1))) m -= (longint'(1) << AW);
      return m;
    endfunction

    function automatic bit in_range(input longint s);
      if (SG != 0) return (s >= -(longint'(1) << (AW - 1))) && (s < (longint'(1) << (AW - 1)));
      return (s >= 0) && (s < (longint'(1) << AW));
    endfunction

    function automatic logic [L-1:0][15:0] fill(input logic [15:0] val);
      logic [L-1:0][15:0] v;
      for (int i = 0; i < L; i++) v[i] = val;
      return v;
    endfunction

    function automatic logic [L-1:0][15:0] ramp();
      logic [L-1:0][15:0] v;
      for (int i = 0; i < L; i++) v[i] = 16'(i + 1);
      return v;
    endfunction

    function automatic logic [L-1:0][15:0] rnd();
      logic [L-1:0][15:0] v;
      for (int i = 0; i < L; i++) v[i] = 16'($urandom_range(0, 65535));
      return v;
    endfunction

    // Packet model: integer beat sum, wrapped accumulator, sticky range violation.
    task automatic model_beat(input logic [L-1:0][15:0] v, input bit last, input bit lat,
                              input int acc_cyc);
      longint bs, s;
      exp_t   e;
      bs = 0;
      for (int i = 0; i < L; i++) bs += (SG != 0) ? longint'($signed(v[i])) : longint'(v[i]);
      s = (m_first ? 0 : m_acc) + bs;
      if (m_first) m_ovf = 1'b0;
      if (!in_range(s)) m_ovf = 1'b1;
      m_acc = wrap(s);
      if (last) begin
        e.sum = m_acc; e.ovf = m_ovf; e.acc_cyc = acc_cyc; e.lat = lat;
        sb.push_back(e);
        n_pkt++;
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
    endtask

    task automatic send(input logic [L-1:0][15:0] v, input bit last, input bit lat);
      int w;
      w = 0;
      vec = v; il = last; iv = 1'b1;
      @(negedge clk);
      while (!ory && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!ory) begin
        check($sformatf("c%0d o_ready timeout", g), ory, 1);
      end else begin
        model_beat(v, last, lat, cyc + 1);
      end
      @(posedge clk);
      #1;
      iv = 1'b0;
    endtask

    task automatic idle(input int n);
      iv = 1'b0;
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 500) begin
        @(posedge clk);
        #1;
        w++;
      end
      check($sformatf("c%0d drain", g), sb.size(), 0);
    endtask

    initial begin
      ir = 1'b1;
      ph = 0;
      forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
          0: ir = 1'b1;
          1: begin
            ir = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
          end
          default: ir = ($urandom_range(0, 3) != 0);
        endcase
      end
    end

    always @(negedge clk) begin
      exp_t   e;
      longint got;
      if (rst_n === 1'b1) begin
        check($sformatf("c%0d o_ready rule", g), ory, !(ov && !ir));
        if (ov && ir) begin
          if (sb.size() == 0) begin
            check($sformatf("c%0d unexpected output", g), ov, 0);
          end else begin
            e   = sb.pop_front();
            got = (SG != 0) ? longint'($signed(os)) : longint'(os);
            check($sformatf("c%0d o_sum", g), got, e.sum);
            check($sformatf("c%0d o_ovf", g), oo, e.ovf);
            if (e.lat) check($sformatf("c%0d latency", g), cyc - e.acc_cyc + 1, S + 1);
            n_out++;
          end
        end
      end
    end

    initial begin
      logic [L-1:0][15:0] v;
      rst_n = 1'b0; iv = 1'b0; il = 1'b0; vec = '0; ready_mode = 0;
      m_first = 1'b1; m_acc = 0; m_ovf = 1'b0; n_out = 0; n_pkt = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check($sformatf("c%0d reset o_valid", g), ov, 0);
      check($sformatf("c%0d reset o_sum", g), os, 0);
      check($sformatf("c%0d reset o_ovf", g), oo, 0);
      check($sformatf("c%0d reset o_ready", g), ory, 1);
      @(posedge clk);
      #1;

      send(fill(16'hFFFF), 1'b1, 1'b1);
      idle(S + 3);
      send(fill(16'hFFFF), 1'b0, 1'b0);
      send(fill(16'hFFFF), 1'b1, 1'b1);
      idle(S + 3);
      send(fill(16'h0000), 1'b1, 1'b1);
      idle(S + 3);
      send(fill(16'hFFFF), 1'b0, 1'b0);
      send(fill(16'hFFFF), 1'b0, 1'b0);
      send(fill(16'hFFFF), 1'b1, 1'b1);
      idle(S + 3);
      send(ramp(), 1'b1, 1'b1);
      idle(S + 3);

      // Reset with non-last beats still in the tree pipeline.
      drain();
      send(fill(16'h0001), 1'b0, 1'b0);
      send(fill(16'h0001), 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_first = 1'b1;
      m_acc   = 0;
      @(negedge clk);
      check($sformatf("c%0d o_valid after reset", g), ov, 0);
      @(posedge clk);
      #1;
      send(fill(16'h0002), 1'b1, 1'b1);
      idle(S + 3);

      ready_mode = 1;
      for (int k = 0; k < 10; k++) begin
        v = '0;
        v[0] = 16'(k);
        send(v, 1'b1, 1'b0);
      end
      drain();

      ready_mode = 2;
      repeat (300) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send(rnd(), $urandom_range(0, 2) == 0, 1'b0);
      end
      send(rnd(), 1'b1, 1'b0);
      drain();
      ready_mode = 0;
      idle(4);
      check($sformatf("c%0d output count", g), n_out, n_pkt);
      n_done++;
    end
  end

  initial begin
    int w;
    w = 0;
    while (n_done < NCFG && w < 60000) begin
      @(posedge clk);
      w++;
    end
    check("all configs done", n_done, NCFG);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
